// File: rtl/mips_host_loader_pkg.sv
// Shared definitions for the MIPS host loader: word width, HLT opcode and FSM encoding.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [5:0]  OPC_HLT = 6'h3f;

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_RD    = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

endpackage

// File: rtl/mips_host_loader_if.sv
// Host stream, instruction-memory write, processor control and readback signals of the loader.
interface mips_host_loader_if
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              cpu_start;
    logic              cpu_halted;
    logic [4:0]        reg_raddr;
    logic [WORD_W-1:0] reg_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              err_overflow;

    modport master (
        input  in_valid, in_data, cpu_halted, reg_rdata, out_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_start, reg_raddr,
               out_valid, out_data, out_last, busy, err_overflow
    );

    modport slave (
        output in_valid, in_data, cpu_halted, reg_rdata, out_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_start, reg_raddr,
               out_valid, out_data, out_last, busy, err_overflow
    );
endinterface

// File: rtl/mips_host_loader.sv
// Loads a program into instruction memory, starts the processor, waits for halt and
// streams registers R0..R(DUMP_REGS-1) back to the host.
module mips_host_loader
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned DUMP_REGS = 6
) (
    input logic                clk1,
    input logic                rst_n,
    mips_host_loader_if.master bus
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [4:0]        k_q, k_d;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [WORD_W-1:0] mem_wdata_q;
    logic              err_q;
    logic              first_q;
    logic [WORD_W-1:0] hold_q;

    logic accept;
    logic is_hlt;
    logic at_cap;
    logic is_last;

    assign accept  = in_ready_q && bus.in_valid;
    assign is_hlt  = (bus.in_data[31:26] == OPC_HLT);
    assign at_cap  = (wr_ptr_q == ADDR_W'(MAX_WORDS - 1));
    assign is_last = (k_q == 5'(DUMP_REGS - 1));

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        k_d      = k_q;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (is_hlt) begin
                        state_d = S_START;
                    end else if (at_cap) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (bus.cpu_halted) begin
                    k_d     = '0;
                    state_d = S_RD;
                end
            end
            S_RD: state_d = S_OUT;
            S_OUT: begin
                if (bus.out_ready) begin
                    if (is_last) begin
                        k_d      = '0;
                        wr_ptr_d = '0;
                        state_d  = S_LOAD;
                    end else begin
                        k_d     = k_q + 5'd1;
                        state_d = S_RD;
                    end
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    // in_ready is registered off the next state so it stays low throughout reset
    // and rises only on the first edge after release.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            wr_ptr_q    <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            first_q     <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            k_q        <= k_d;
            in_ready_q <= (state_d == S_LOAD);
            mem_we_q   <= accept;
            if (accept) begin
                mem_addr_q  <= wr_ptr_q;
                mem_wdata_q <= bus.in_data;
            end
            if (accept && !is_hlt && at_cap) begin
                err_q <= 1'b1;
            end
            first_q <= (state_q == S_RD);
            if (first_q) begin
                hold_q <= bus.reg_rdata;
            end
        end
    end

    // First OUT cycle forwards reg_rdata directly; afterwards the captured copy is held.
    assign bus.in_ready     = in_ready_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.cpu_start    = (state_q == S_START);
    assign bus.reg_raddr    = k_q;
    assign bus.out_valid    = (state_q == S_OUT);
    assign bus.out_data     = first_q ? bus.reg_rdata : hold_q;
    assign bus.out_last     = (state_q == S_OUT) && is_last;
    assign bus.busy         = !((state_q == S_LOAD) && (wr_ptr_q == '0));
    assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_mips_host_loader.sv
// Scoreboard bench for mips_host_loader: main instance plus a MAX_WORDS=4 instance for overflow.
module tb_mips_host_loader;
    import mips_pkg::*;

    logic clk1  = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk1 = ~clk1;

    mips_host_loader_if #(.ADDR_W(10)) bus1 ();
    mips_host_loader_if #(.ADDR_W(10)) bus2 ();

    mips_host_loader #(.ADDR_W(10), .MAX_WORDS(1024), .DUMP_REGS(6)) dut (
        .clk1(clk1), .rst_n(rst_n), .bus(bus1)
    );
    mips_host_loader #(.ADDR_W(10), .MAX_WORDS(4), .DUMP_REGS(6)) dut_ovf (
        .clk1(clk1), .rst_n(rst_n), .bus(bus2)
    );

    // Register file model: Reg[k] = k, combinational on the held read address.
    assign bus1.reg_rdata = 32'(bus1.reg_raddr);
    assign bus2.reg_rdata = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] prog[$];
    int unsigned exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] rd_data_q[$];
    logic        rd_last_q[$];

    function automatic logic [85:0] snap1();
        return {bus1.in_ready, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.cpu_start,
                bus1.reg_raddr, bus1.out_valid, bus1.out_data, bus1.out_last, bus1.busy,
                bus1.err_overflow};
    endfunction

    function automatic logic [85:0] snap2();
        return {bus2.in_ready, bus2.mem_we, bus2.mem_addr, bus2.mem_wdata, bus2.cpu_start,
                bus2.reg_raddr, bus2.out_valid, bus2.out_data, bus2.out_last, bus2.busy,
                bus2.err_overflow};
    endfunction

    task automatic load_prog(input int unsigned gap_pct);
        int          idx = 0;
        int          ncyc = 0;
        int unsigned next_addr = 0;
        bit          acc, acc_hlt, done;
        int unsigned ea;
        logic [31:0] ed;
        done = 0;
        exp_addr_q.delete();
        exp_data_q.delete();
        while (!done && ncyc < 400) begin
            if (idx < prog.size() && $urandom_range(99) >= gap_pct) begin
                bus1.in_valid = 1'b1;
                bus1.in_data  = prog[idx];
            end else begin
                bus1.in_valid = 1'b0;
                bus1.in_data  = $urandom;
            end
            acc     = bus1.in_valid && bus1.in_ready;
            acc_hlt = acc && (bus1.in_data[31:26] == OPC_HLT);
            if (acc) begin
                exp_addr_q.push_back(next_addr);
                exp_data_q.push_back(bus1.in_data);
                next_addr++;
                idx++;
            end
            @(posedge clk1); #1;
            bus1.in_valid = 1'b0;
            ncyc++;
            checks++;
            if (bus1.mem_we !== acc)
                begin errors++; $display("FAIL load_we: got %b expected %b", bus1.mem_we, acc); end
            if (bus1.mem_we === 1'b1 && exp_addr_q.size() != 0) begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                checks++;
                if (bus1.mem_addr !== 10'(ea) || bus1.mem_wdata !== ed)
                    begin errors++; $display("FAIL load_write: got %0d/%h expected %0d/%h",
                                             bus1.mem_addr, bus1.mem_wdata, ea, ed); end
            end
            checks++;
            if (bus1.cpu_start !== acc_hlt)
                begin errors++; $display("FAIL cpu_start: got %b expected %b", bus1.cpu_start, acc_hlt); end
            if (acc_hlt) done = 1;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL load_timeout: got %0d words expected %0d", idx, prog.size()); end
        if (gap_pct == 0) begin
            checks++;
            if (ncyc != prog.size())
                begin errors++; $display("FAIL load_rate: got %0d cycles expected %0d", ncyc, prog.size()); end
        end
    endtask

    // Starts in the cpu_start slot (slot 0). d = cycle in which cpu_halted rises (0: already high).
    task automatic run_dump(input int d, input int stall, input int abort_beat);
        int first_exp = ((d < 1) ? 1 : d) + 2;
        int stall_cnt = 0;
        int beat = 0;
        bit seen = 0;
        bit hs, prev_hs, rdy;
        prev_hs = 0;
        rd_data_q.delete();
        rd_last_q.delete();
        for (int k = 0; k < 6; k++) begin
            rd_data_q.push_back(32'(k));
            rd_last_q.push_back(k == 5);
        end
        if (d > 0) bus1.cpu_halted = 1'b0;
        for (int cur = 0; cur < 500 && rd_data_q.size() != 0; cur++) begin
            if (prev_hs) begin
                checks++;
                if (bus1.out_valid !== 1'b0)
                    begin errors++; $display("FAIL beat_gap: got out_valid=%b expected 0", bus1.out_valid); end
            end
            if (!seen && bus1.out_valid === 1'b1) begin
                seen = 1;
                checks++;
                if (cur != first_exp)
                    begin errors++; $display("FAIL dump_start: got cycle %0d expected %0d", cur, first_exp); end
            end
            if (bus1.out_valid === 1'b1) begin
                checks++;
                if (bus1.out_data !== rd_data_q[0] || bus1.out_last !== rd_last_q[0])
                    begin errors++; $display("FAIL beat: got %h/%b expected %h/%b", bus1.out_data,
                                             bus1.out_last, rd_data_q[0], rd_last_q[0]); end
                checks++;
                if (bus1.reg_raddr !== 5'(beat))
                    begin errors++; $display("FAIL raddr: got %0d expected %0d", bus1.reg_raddr, beat); end
                if (beat == abort_beat) begin
                    #2 rst_n = 1'b0;
                    #1;
                    checks++;
                    if (snap1() !== '0)
                        begin errors++; $display("FAIL async_reset: got %h expected 0", snap1()); end
                    bus1.out_ready = 1'b0;
                    return;
                end
            end
            if (d > 0 && cur == d) bus1.cpu_halted = 1'b1;
            if (bus1.out_valid === 1'b1) begin
                rdy = (stall_cnt >= stall);
                if (!rdy) stall_cnt++;
            end else begin
                rdy = (stall == 0);
            end
            bus1.out_ready = rdy;
            hs = bus1.out_valid && rdy;
            @(posedge clk1); #1;
            prev_hs = hs;
            if (hs) begin
                void'(rd_data_q.pop_front());
                void'(rd_last_q.pop_front());
                beat++;
                stall_cnt = 0;
            end
        end
        bus1.out_ready = 1'b0;
        checks++;
        if (rd_data_q.size() != 0)
            begin errors++; $display("FAIL dump_timeout: got %0d beats expected 6", beat); end
        checks++;
        if (bus1.busy !== 1'b0 || bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 || bus1.reg_raddr !== 5'd0)
            begin errors++; $display("FAIL post_dump: got busy=%b in_ready=%b out_valid=%b raddr=%0d expected 0/1/0/0",
                                     bus1.busy, bus1.in_ready, bus1.out_valid, bus1.reg_raddr); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk1);
        #1;
        checks++;
        if (snap1() !== '0) begin errors++; $display("FAIL reset_vals: got %h expected 0", snap1()); end
        checks++;
        if (snap2() !== '0) begin errors++; $display("FAIL reset_vals_ovf: got %h expected 0", snap2()); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus1.in_ready !== 1'b0) begin errors++; $display("FAIL ready_early: got %b expected 0", bus1.in_ready); end
        @(posedge clk1); #1;
        checks++;
        if (bus1.in_ready !== 1'b1 || bus1.busy !== 1'b0)
            begin errors++; $display("FAIL ready_rise: got %b/%b expected 1/0", bus1.in_ready, bus1.busy); end
    endtask

    task automatic test_load_and_dump();
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        load_prog(0);
        run_dump(50, 0, -1);
    endtask

    task automatic test_backpressure();
        load_prog(0);
        run_dump(5, 3, -1);
    endtask

    task automatic test_gappy_early_halt();
        prog.delete();
        for (int i = 0; i < 7; i++) prog.push_back({6'h0a, 26'($urandom)});
        prog.push_back(32'hfc000000);
        bus1.cpu_halted = 1'b1;
        repeat (2) @(posedge clk1);
        #1;
        load_prog(40);
        run_dump(0, 1, -1);
        bus1.cpu_halted = 1'b0;
    endtask

    task automatic test_overflow();
        int          idx = 0;
        int unsigned ea = 0;
        bit          acc;
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus2.in_valid = (idx < 5);
            bus2.in_data  = 32'h1000_0000 + 32'(idx);
            acc = bus2.in_valid && bus2.in_ready;
            @(posedge clk1); #1;
            checks++;
            if (bus2.mem_we !== acc) begin errors++; $display("FAIL ovf_we: got %b expected %b", bus2.mem_we, acc); end
            if (acc) begin
                checks++;
                if (bus2.mem_addr !== 10'(ea) || bus2.mem_wdata !== 32'h1000_0000 + 32'(idx))
                    begin errors++; $display("FAIL ovf_write: got %0d/%h expected %0d/%h", bus2.mem_addr,
                                             bus2.mem_wdata, ea, 32'h1000_0000 + 32'(idx)); end
                ea++;
                idx++;
            end
            checks++;
            if (bus2.cpu_start !== 1'b0) begin errors++; $display("FAIL ovf_start: got %b expected 0", bus2.cpu_start); end
        end
        bus2.in_valid = 1'b0;
        checks++;
        if (idx != 4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", idx); end
        checks++;
        if (bus2.err_overflow !== 1'b1 || bus2.in_ready !== 1'b0 || bus2.busy !== 1'b1)
            begin errors++; $display("FAIL ovf_flags: got err=%b ready=%b busy=%b expected 1/0/1",
                                     bus2.err_overflow, bus2.in_ready, bus2.busy); end
    endtask

    task automatic test_reset_mid_dump();
        prog = '{32'h28010007, 32'h00222000, 32'hfc000000};
        load_prog(0);
        run_dump(5, 1, 2);
        repeat (2) @(posedge clk1);
        #1;
        checks++;
        if (snap1() !== '0 || snap2() !== '0)
            begin errors++; $display("FAIL reset_hold: got %h/%h expected 0", snap1(), snap2()); end
        rst_n = 1'b1;
        @(posedge clk1); #1;
        checks++;
        if (bus1.in_ready !== 1'b1 || bus1.busy !== 1'b0 || bus1.out_valid !== 1'b0)
            begin errors++; $display("FAIL reset_release: got %b/%b/%b expected 1/0/0",
                                     bus1.in_ready, bus1.busy, bus1.out_valid); end
        prog = '{32'h0ce77800, 32'h00832800, 32'h2801000a, 32'hfc000000};
        load_prog(0);
        run_dump(3, 0, -1);
    endtask

    initial begin
        bus1.in_valid = 1'b0;  bus1.in_data = '0;  bus1.cpu_halted = 1'b0;  bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0;  bus2.in_data = '0;  bus2.cpu_halted = 1'b0;  bus2.out_ready = 1'b0;
        test_reset();
        test_load_and_dump();
        test_backpressure();
        test_gappy_early_halt();
        test_overflow();
        test_reset_mid_dump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_host_loader.md
# mips_host_loader

Host-side load/readback engine for the two-phase MIPS pipeline, doing in hardware what the bench does hierarchically. It accepts a program as a stream of 32-bit words and writes them into instruction memory from address 0 until a HLT word. It then pulses the processor start, waits for the processor to halt, and streams the first DUMP_REGS general registers back out.

## Interface
- ADDR_W, 10: instruction-memory word-address width.
- MAX_WORDS, 1024: program capacity in words; must be ≤ 2**ADDR_W.
- DUMP_REGS, 6: registers read back, R0..R(DUMP_REGS-1); 1..32.

- clk1  in  1  single clock, rising edge; the block uses only this clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  host word valid.
- in_ready  out  1  block accepts a word; transfer on in_valid && in_ready.
- in_data  in  32  program word.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  write data.
- cpu_start  out  1  one-cycle pulse; the processor clears PC, HALTED and TAKEN_BRANCH.
- cpu_halted  in  1  processor HALTED flag, level.
- reg_raddr  out  5  register-file read address.
- reg_rdata  in  32  register data, valid the cycle after reg_raddr.
- out_valid  out  1  readback word valid.
- out_ready  in  1  host accepts readback word.
- out_data  out  32  register value.
- out_last  out  1  marks the R(DUMP_REGS-1) beat.
- busy  out  1  high in every state except LOAD with zero words accepted.
- err_overflow  out  1  sticky; cleared only by reset.

## Operation
- **LOAD:** in_ready=1. Each accepted word is written at wr_ptr, and wr_ptr then increments.
  - Accepted word with in_data[31:26]==6'h3f (HLT): go to START.
  - Word accepted at wr_ptr==MAX_WORDS-1 that is not HLT: it is still written, err_overflow is set, go to ERR.
- **START:** cpu_start=1 for exactly one cycle, then go to RUN.
- **RUN:** wait for cpu_halted==1, sampled from the first RUN cycle onward. A cpu_halted already high during START is ignored. On halt, set k=0 and go to RD.
- **RD:** reg_raddr=k for one cycle, then go to OUT.
- **OUT:** out_data is captured from reg_rdata on entry and held stable with out_valid=1 until out_ready.
  - out_last=1 when k==DUMP_REGS-1.
  - On handshake: if last, clear wr_ptr and go to LOAD; otherwise k+1 and go to RD.
- **ERR:** all handshakes idle; held until reset.
- in_valid outside LOAD is ignored (in_ready=0).
- out_ready outside OUT is ignored.
- reg_raddr holds k in every state, 0 outside the dump.

## Timing
- **Reset values:** in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_start=0, reg_raddr=0, out_valid=0, out_data=0, out_last=0, busy=0, err_overflow=0. State is LOAD, wr_ptr=0, k=0.
- in_ready rises in the first cycle after rst_n deasserts.
- Word accepted at edge N: mem_we/mem_addr/mem_wdata are registered and high during cycle N+1.
- Back-to-back acceptance is sustained at 1 word/cycle.
- HLT accepted at edge N: its write is in cycle N+1 and cpu_start is high in cycle N+1. The write and the start pulse coincide; the processor's first fetch comes after the write by the processor's own pipeline timing.
- Readback: each beat costs RD (1) + OUT (≥1) cycles. The minimum is 2 cycles/beat, with out_valid low for one cycle between beats.
- Asynchronous reset mid-operation aborts immediately. An in-flight mem_we is dropped, and no partial beat or pulse is emitted after release.

## Structure
- Shared package mips_pkg holds:
  - OPC_HLT=6'h3f
  - the state encoding (LOAD, START, RUN, RD, OUT, ERR)
  - the 32-bit word width constant, also used by the processor.
- Single module with no sub-module: one FSM, counters wr_ptr and k, and the output holding register.

## Test plan
- **Program load:** stream 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 with no gaps.
  - Required: mem writes to addr 0..8 with the same data, one per cycle.
  - Required: cpu_start as one pulse coincident with the addr-8 write.
- **Halt wait / readback:** model the register file as Reg[k]=k and raise cpu_halted 50 cycles after the start pulse.
  - Required: 6 beats with data 0..5, out_last only on value 5.
  - Required: busy drops after the last beat and in_ready=1.
- **Backpressure:** hold out_ready low for 3 cycles on each beat.
  - Required: out_data and out_last stable while stalled; no beat lost or duplicated.
- **Overflow:** MAX_WORDS=4, send 5 non-HLT words.
  - Required: 4 writes (addr 0..3) and err_overflow=1.
  - Required: the 5th word is not accepted, cpu_start never pulses, in_ready stays 0.
- **Gappy input / early halt:** insert random in_valid gaps, and hold cpu_halted high before start.
  - Required: writes remain contiguous from addr 0, and the dump starts only when RUN samples cpu_halted high.
- **Reset mid-dump:** assert rst_n low during the 3rd beat.
  - Required: all outputs return to their reset values asynchronously.
  - Required: a new program after release loads from addr 0.
